// File: rtl/wash_cycle_timer_if.sv
// Controller-side signal bundle for wash_cycle_timer: start/pause/abort commands in,
// done pulse, status and remaining-time readout out.
interface wash_cycle_timer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             timer_start;
  logic [WIDTH-1:0] timer_value;
  logic             timer_pause;
  logic             timer_abort;
  logic             timer_done;
  logic             busy;
  logic             paused;
  logic [WIDTH-1:0] remaining;
  logic             agitate_dir;
  logic             pause_timeout;

  modport master (
    output timer_start, timer_value, timer_pause, timer_abort,
    input  timer_done, busy, paused, remaining, agitate_dir, pause_timeout
  );

  modport slave (
    input  timer_start, timer_value, timer_pause, timer_abort,
    output timer_done, busy, paused, remaining, agitate_dir, pause_timeout
  );
endinterface

// File: rtl/wash_cycle_timer.sv
// Prescaled countdown timer with pause, abort and motor agitation toggle.
// Optional pause auto-abort is built when TIMER_PAUSE_TIMEOUT_EN is defined.
module wash_cycle_timer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned PRESCALE       = 1,
  parameter int unsigned AGITATE_PERIOD = 1048576,
  parameter int unsigned PAUSE_LIMIT    = 60000000
) (
  input logic               clk,
  input logic               reset,
  wash_cycle_timer_if.slave tif
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned AgW = (AGITATE_PERIOD > 1) ? $clog2(AGITATE_PERIOD) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);
  localparam logic [AgW-1:0] AgLast = AgW'(AGITATE_PERIOD - 1);

  if (PRESCALE < 1 || AGITATE_PERIOD < 1 || PAUSE_LIMIT < 1) begin : g_param_check
    $error("wash_cycle_timer: PRESCALE, AGITATE_PERIOD and PAUSE_LIMIT must be >= 1");
  end

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [PsW-1:0]   presc_q, presc_d;
  logic [AgW-1:0]   agit_q, agit_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             paused_q, paused_d;
  logic             pto_q, pto_d;

`ifdef TIMER_PAUSE_TIMEOUT_EN
  localparam int unsigned PcW = $clog2(PAUSE_LIMIT + 1);
  localparam logic [PcW-1:0] PcLast = PcW'(PAUSE_LIMIT - 1);
  logic [PcW-1:0] pcnt_q, pcnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    presc_d  = presc_q;
    agit_d   = agit_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    pto_d    = 1'b0;
`ifdef TIMER_PAUSE_TIMEOUT_EN
    pcnt_d   = '0;
`endif

    if (tif.timer_abort) begin
      state_d = StIdle;
      rem_d   = '0;
      presc_d = '0;
      agit_d  = '0;
    end else if (tif.timer_start) begin
      presc_d = '0;
      agit_d  = '0;
      dir_d   = 1'b0;
      if (tif.timer_value == '0) begin
        state_d = StIdle;
        rem_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d = StRun;
        rem_d   = tif.timer_value;
      end
    end else if (state_q == StRun) begin
      if (!tif.timer_pause) begin
        if (presc_q == PsLast) begin
          presc_d = '0;
          // Guarding with <= 1 keeps remaining from ever wrapping below zero.
          if (rem_q <= WIDTH'(1)) begin
            rem_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - WIDTH'(1);
          end
        end else begin
          presc_d = presc_q + PsW'(1);
        end

        if (agit_q == AgLast) begin
          agit_d = '0;
          dir_d  = ~dir_q;
        end else begin
          agit_d = agit_q + AgW'(1);
        end
      end else begin
`ifdef TIMER_PAUSE_TIMEOUT_EN
        if (pcnt_q == PcLast) begin
          state_d = StIdle;
          rem_d   = '0;
          presc_d = '0;
          agit_d  = '0;
          pto_d   = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PcW'(1);
        end
`endif
      end
    end

    paused_d = (state_d == StRun) && tif.timer_pause;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      presc_q  <= '0;
      agit_q   <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
      paused_q <= 1'b0;
      pto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      presc_q  <= presc_d;
      agit_q   <= agit_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      paused_q <= paused_d;
      pto_q    <= pto_d;
    end
  end

`ifdef TIMER_PAUSE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`endif

  assign tif.busy          = (state_q == StRun);
  assign tif.paused        = paused_q;
  assign tif.remaining     = rem_q;
  assign tif.timer_done    = done_q;
  assign tif.agitate_dir   = dir_q;
  assign tif.pause_timeout = pto_q;

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Randomized and scenario-driven bench for wash_cycle_timer; two instances
// (PRESCALE 4 and 1) share stimulus and are checked against an elapsed-cycle model.
module tb_wash_cycle_timer;

  localparam int unsigned Width    = 32;
  localparam int unsigned AgPeriod = 3;
  localparam int unsigned PLimit   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             d_start, d_pause, d_abort;
  logic [Width-1:0] d_value;

  wash_cycle_timer_if #(.WIDTH(Width)) tif_a ();
  wash_cycle_timer_if #(.WIDTH(Width)) tif_b ();

  assign tif_a.timer_start = d_start;
  assign tif_a.timer_value = d_value;
  assign tif_a.timer_pause = d_pause;
  assign tif_a.timer_abort = d_abort;
  assign tif_b.timer_start = d_start;
  assign tif_b.timer_value = d_value;
  assign tif_b.timer_pause = d_pause;
  assign tif_b.timer_abort = d_abort;

  wash_cycle_timer #(
    .WIDTH(Width), .PRESCALE(4), .AGITATE_PERIOD(AgPeriod), .PAUSE_LIMIT(PLimit)
  ) u_dut_a (
    .clk  (clk),
    .reset(rst),
    .tif  (tif_a)
  );

  wash_cycle_timer #(
    .WIDTH(Width), .PRESCALE(1), .AGITATE_PERIOD(AgPeriod), .PAUSE_LIMIT(PLimit)
  ) u_dut_b (
    .clk  (clk),
    .reset(rst),
    .tif  (tif_b)
  );

  logic [31:0] o_rem[2];
  logic        o_done[2], o_busy[2], o_paused[2], o_dir[2], o_pto[2];
  assign o_rem[0] = tif_a.remaining;     assign o_rem[1] = tif_b.remaining;
  assign o_done[0] = tif_a.timer_done;   assign o_done[1] = tif_b.timer_done;
  assign o_busy[0] = tif_a.busy;         assign o_busy[1] = tif_b.busy;
  assign o_paused[0] = tif_a.paused;     assign o_paused[1] = tif_b.paused;
  assign o_dir[0] = tif_a.agitate_dir;   assign o_dir[1] = tif_b.agitate_dir;
  assign o_pto[0] = tif_a.pause_timeout; assign o_pto[1] = tif_b.pause_timeout;

  // Model: a run is "loaded N, c counting cycles elapsed"; everything follows from c.
  bit m_run[2];
  int m_n[2], m_c[2], m_pcnt[2];
  int m_rem[2];
  bit m_dir[2], m_done[2], m_paused[2], m_pto[2];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int presc_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    m_done[i] = 1'b0;
    m_pto[i]  = 1'b0;
    if (rst) begin
      m_run[i] = 1'b0; m_rem[i] = 0; m_c[i] = 0; m_dir[i] = 1'b0; m_pcnt[i] = 0;
    end else if (d_abort) begin
      m_run[i] = 1'b0; m_rem[i] = 0; m_c[i] = 0; m_pcnt[i] = 0;
    end else if (d_start) begin
      m_c[i] = 0; m_dir[i] = 1'b0; m_pcnt[i] = 0; m_n[i] = int'(d_value);
      m_run[i] = (d_value != 0);
      m_rem[i] = int'(d_value);
      m_done[i] = (d_value == 0);
    end else if (m_run[i] && !d_pause) begin
      m_c[i]++;
      m_pcnt[i] = 0;
      m_dir[i] = ((m_c[i] / AgPeriod) % 2) == 1;
      m_rem[i] = m_n[i] - m_c[i] / presc_of(i);
      if (m_rem[i] == 0) begin
        m_run[i] = 1'b0;
        m_done[i] = 1'b1;
      end
    end else if (m_run[i] && d_pause) begin
`ifdef TIMER_PAUSE_TIMEOUT_EN
      m_pcnt[i]++;
      if (m_pcnt[i] == PLimit) begin
        m_run[i] = 1'b0; m_rem[i] = 0; m_c[i] = 0; m_pcnt[i] = 0; m_pto[i] = 1'b1;
      end
`endif
    end
    m_paused[i] = m_run[i] && d_pause && !rst;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      string p;
      p = (i == 0) ? "a." : "b.";
      check({p, "remaining"}, o_rem[i], m_rem[i]);
      check({p, "timer_done"}, 32'(o_done[i]), 32'(m_done[i]));
      check({p, "busy"}, 32'(o_busy[i]), 32'(m_run[i]));
      check({p, "paused"}, 32'(o_paused[i]), 32'(m_paused[i]));
      check({p, "agitate_dir"}, 32'(o_dir[i]), 32'(m_dir[i]));
      check({p, "pause_timeout"}, 32'(o_pto[i]), 32'(m_pto[i]));
    end
  endtask

  task automatic step(input bit s, input int v, input bit p, input bit ab, input bit r);
    d_start = s; d_value = Width'(v); d_pause = p; d_abort = ab; rst = r;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  // Idle steps until instance i reports done; lat = edges after the start edge.
  task automatic run_to_done(input int i, input string tag, output int lat);
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      step(0, 0, 0, 0, 0);
      lat++;
      if (o_done[i]) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: no timer_done within 200 cycles", tag);
    lat = -1;
  endtask

  int  lat;
  bit  p_hold;
  bit  saw_pto;

  initial begin
    d_start = 0; d_value = '0; d_pause = 0; d_abort = 0; rst = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("reset.remaining", o_rem[0], 32'd0);
    check("reset.busy", 32'(o_busy[1]), 32'd0);

    // PRESCALE=4, N=3: done 12 edges after start.
    step(1, 3, 0, 0, 0);
    check("s1.rem_after_start", o_rem[0], 32'd3);
    run_to_done(0, "s1.done", lat);
    check("s1.latency", lat, 32'd12);
    check("s1.busy_with_done", 32'(o_busy[0]), 32'd0);
    step(0, 0, 0, 0, 0);
    check("s1.done_one_cycle", 32'(o_done[0]), 32'd0);

    // PRESCALE=1, N=10, 5-cycle pause after edge 3: done at 15.
    step(1, 10, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    check("s2.rem_before_pause", o_rem[1], 32'd7);
    repeat (5) step(0, 0, 1, 0, 0);
    check("s2.rem_frozen", o_rem[1], 32'd7);
    check("s2.paused", 32'(o_paused[1]), 32'd1);
    run_to_done(1, "s2.done", lat);
    check("s2.latency", lat + 8, 32'd15);

    // N=0: done next cycle, never busy.
    step(1, 0, 0, 0, 0);
    check("s3.done", 32'(o_done[1]), 32'd1);
    check("s3.busy", 32'(o_busy[1]), 32'd0);

    // Restart N=5 at remaining 2 of an N=20 run.
    step(1, 20, 0, 0, 0);
    repeat (18) step(0, 0, 0, 0, 0);
    check("s4.rem_at_restart", o_rem[1], 32'd2);
    step(1, 5, 0, 0, 0);
    run_to_done(1, "s4.done", lat);
    check("s4.latency", lat, 32'd5);

    // Abort concurrent with start at remaining 30, then reset mid-run.
    step(1, 50, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0);
    check("s5.rem_before_abort", o_rem[1], 32'd30);
    step(1, 7, 0, 1, 0);
    check("s5.abort_busy", 32'(o_busy[1]), 32'd0);
    check("s5.abort_rem", o_rem[1], 32'd0);
    step(1, 50, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("s5.reset_rem", o_rem[0], 32'd0);
    check("s5.reset_dir", 32'(o_dir[1]), 32'd0);

    // N=12 with 4-cycle pause, then a 10-cycle pause for the timeout path.
    step(1, 12, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    check("s6.dir_after_4", 32'(o_dir[1]), 32'd1);
    repeat (4) step(0, 0, 1, 0, 0);
    check("s6.dir_held", 32'(o_dir[1]), 32'd1);
    run_to_done(1, "s6.done", lat);
    step(1, 12, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    saw_pto = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 0, 0);
      if (o_pto[1]) saw_pto = 1;
    end
`ifdef TIMER_PAUSE_TIMEOUT_EN
    check("s6.pto_seen", 32'(saw_pto), 32'd1);
    check("s6.pto_busy", 32'(o_busy[1]), 32'd0);
`else
    check("s6.pto_seen", 32'(saw_pto), 32'd0);
    check("s6.pause_holds", 32'(o_busy[1]), 32'd1);
`endif
    step(0, 0, 0, 0, 1);

    // Randomized traffic.
    p_hold = 0;
    for (int k = 0; k < 4000; k++) begin
      bit s, ab, r;
      int v;
      s  = ($urandom_range(99) < 6);
      v  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(30, 1));
      ab = ($urandom_range(99) < 2);
      r  = ($urandom_range(199) == 0);
      if ($urandom_range(99) < 10) p_hold = ~p_hold;
      step(s, v, p_hold, ab, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
